// File: rtl/alarm_ring_controller.sv
// Alarm ring sequencer: time match -> ring with 1 s beep gating, snooze/dismiss, unattended timeout.
// All state changes land one clk after the qualifying input; there is no backpressure.
module alarm_ring_controller #(
  parameter int SNOOZE_MINS = 9,
  parameter int MAX_SNOOZES = 3,
  parameter int RING_SECS   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [7:0] current_hours,
  input  logic [7:0] current_mins,
  input  logic [7:0] alarm_hours,
  input  logic [7:0] alarm_mins,
  input  logic       alarm_enabled,
  input  logic       btn_snooze,
  input  logic       btn_dismiss,
  output logic       alarm_triggered,
  output logic       sound_en,
  output logic       snoozing,
  output logic [3:0] snooze_count,
  output logic [7:0] wake_hours,
  output logic [7:0] wake_mins
);

  localparam int             RW         = (RING_SECS < 2) ? 1 : $clog2(RING_SECS + 1);
  localparam logic [RW-1:0]  RING_LAST  = RW'(RING_SECS - 1);
  localparam logic [3:0]     SNOOZE_MAX = 4'(MAX_SNOOZES);
  localparam logic [8:0]     SNOOZE_ADD = 9'(SNOOZE_MINS);

  typedef enum logic [2:0] {
    S_DISARMED,
    S_ARMED,
    S_RINGING,
    S_SNOOZED,
    S_COOLDOWN
  } state_t;

  state_t          r_state;
  logic            r_sound;
  logic [RW-1:0]   r_ring_secs;
  logic [3:0]      r_snooze_count;
  logic [7:0]      r_wake_hours;
  logic [7:0]      r_wake_mins;
  logic [7:0]      r_cool_mins;

  state_t          w_state_nxt;
  logic            w_sound_nxt;
  logic [RW-1:0]   w_ring_secs_nxt;
  logic [3:0]      w_snooze_count_nxt;
  logic [7:0]      w_wake_hours_nxt;
  logic [7:0]      w_wake_mins_nxt;
  logic [7:0]      w_cool_mins_nxt;

  logic            w_go_ring;
  logic            w_go_snooze;
  logic            w_go_cool;

  logic [8:0]      w_min_sum;
  logic            w_min_wrap;
  logic [7:0]      w_hr_inc;
  logic [7:0]      w_snz_hours;
  logic [7:0]      w_snz_mins;
  logic            w_alarm_match;
  logic            w_wake_match;
  logic            w_can_snooze;
  logic            w_timeout;

  // Wake time is taken from the live clock at the moment the snooze is accepted.
  assign w_min_sum   = {1'b0, current_mins} + SNOOZE_ADD;
  assign w_min_wrap  = (w_min_sum >= 9'd60);
  assign w_snz_mins  = w_min_wrap ? 8'(w_min_sum - 9'd60) : w_min_sum[7:0];
  assign w_hr_inc    = current_hours + 8'd1;
  assign w_snz_hours = !w_min_wrap         ? current_hours :
                       (w_hr_inc >= 8'd24) ? (w_hr_inc - 8'd24) : w_hr_inc;

  assign w_alarm_match = (current_hours == alarm_hours) && (current_mins == alarm_mins);
  assign w_wake_match  = (current_hours == r_wake_hours) && (current_mins == r_wake_mins);
  assign w_can_snooze  = (r_snooze_count < SNOOZE_MAX);
  assign w_timeout     = sec_tick && (r_ring_secs == RING_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_DISARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sound        <= 1'b0;
      r_ring_secs    <= '0;
      r_snooze_count <= 4'd0;
      r_wake_hours   <= 8'd0;
      r_wake_mins    <= 8'd0;
      r_cool_mins    <= 8'd0;
    end else begin
      r_sound        <= w_sound_nxt;
      r_ring_secs    <= w_ring_secs_nxt;
      r_snooze_count <= w_snooze_count_nxt;
      r_wake_hours   <= w_wake_hours_nxt;
      r_wake_mins    <= w_wake_mins_nxt;
      r_cool_mins    <= w_cool_mins_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_sound_nxt        = r_sound;
    w_ring_secs_nxt    = r_ring_secs;
    w_snooze_count_nxt = r_snooze_count;
    w_wake_hours_nxt   = r_wake_hours;
    w_wake_mins_nxt    = r_wake_mins;
    w_cool_mins_nxt    = r_cool_mins;
    w_go_ring          = 1'b0;
    w_go_snooze        = 1'b0;
    w_go_cool          = 1'b0;

    unique case (r_state)
      S_DISARMED: begin
        w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_alarm_match) begin
          w_go_ring          = 1'b1;
          w_snooze_count_nxt = 4'd0;
        end
      end
      S_RINGING: begin
        if (sec_tick) begin
          w_ring_secs_nxt = r_ring_secs + RW'(1);
          w_sound_nxt     = ~r_sound;
        end
        // Buttons outrank the timeout; a snooze at the limit falls through to it.
        if (btn_dismiss) begin
          w_go_cool = 1'b1;
        end else if (btn_snooze && w_can_snooze) begin
          w_go_snooze = 1'b1;
        end else if (w_timeout) begin
          w_go_snooze = w_can_snooze;
          w_go_cool   = !w_can_snooze;
        end
      end
      S_SNOOZED: begin
        if (btn_dismiss) begin
          w_go_cool = 1'b1;
        end else if (w_wake_match) begin
          w_go_ring = 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (current_mins != r_cool_mins) begin
          w_state_nxt = S_ARMED;
        end
      end
      default: begin
        w_state_nxt = S_DISARMED;
      end
    endcase

    if (w_go_ring) begin
      w_state_nxt     = S_RINGING;
      w_sound_nxt     = 1'b1;
      w_ring_secs_nxt = '0;
    end
    if (w_go_snooze) begin
      w_state_nxt        = S_SNOOZED;
      w_sound_nxt        = 1'b0;
      w_snooze_count_nxt = r_snooze_count + 4'd1;
      w_wake_hours_nxt   = w_snz_hours;
      w_wake_mins_nxt    = w_snz_mins;
    end
    if (w_go_cool) begin
      w_state_nxt        = S_COOLDOWN;
      w_sound_nxt        = 1'b0;
      w_snooze_count_nxt = 4'd0;
      w_wake_hours_nxt   = 8'd0;
      w_wake_mins_nxt    = 8'd0;
      w_cool_mins_nxt    = current_mins;
    end

    if (!alarm_enabled) begin
      w_state_nxt        = S_DISARMED;
      w_sound_nxt        = 1'b0;
      w_ring_secs_nxt    = '0;
      w_snooze_count_nxt = 4'd0;
      w_wake_hours_nxt   = 8'd0;
      w_wake_mins_nxt    = 8'd0;
      w_cool_mins_nxt    = 8'd0;
    end
  end

  assign alarm_triggered = (r_state == S_RINGING);
  assign sound_en        = r_sound && (r_state == S_RINGING);
  assign snoozing        = (r_state == S_SNOOZED);
  assign snooze_count    = r_snooze_count;
  assign wake_hours      = r_wake_hours;
  assign wake_mins       = r_wake_mins;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Bench for alarm_ring_controller: directed scenarios plus random traffic, scored against a
// minute-of-day reference model.
module tb_alarm_ring_controller;

  localparam int SNOOZE_MINS = 9;
  localparam int MAX_SNOOZES = 3;
  localparam int RING_SECS   = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [7:0] current_hours;
  logic [7:0] current_mins;
  logic [7:0] alarm_hours;
  logic [7:0] alarm_mins;
  logic       alarm_enabled;
  logic       btn_snooze;
  logic       btn_dismiss;
  logic       alarm_triggered;
  logic       sound_en;
  logic       snoozing;
  logic [3:0] snooze_count;
  logic [7:0] wake_hours;
  logic [7:0] wake_mins;

  alarm_ring_controller #(
    .SNOOZE_MINS(SNOOZE_MINS),
    .MAX_SNOOZES(MAX_SNOOZES),
    .RING_SECS  (RING_SECS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sec_tick       (sec_tick),
    .current_hours  (current_hours),
    .current_mins   (current_mins),
    .alarm_hours    (alarm_hours),
    .alarm_mins     (alarm_mins),
    .alarm_enabled  (alarm_enabled),
    .btn_snooze     (btn_snooze),
    .btn_dismiss    (btn_dismiss),
    .alarm_triggered(alarm_triggered),
    .sound_en       (sound_en),
    .snoozing       (snoozing),
    .snooze_count   (snooze_count),
    .wake_hours     (wake_hours),
    .wake_mins      (wake_mins)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Times are kept as minutes since midnight.
  int cur_t;
  int al_t;

  // Reference model: 0 off, 1 armed, 2 ringing, 3 snoozed, 4 cooldown.
  int m_mode;
  int m_snz;
  int m_ringsec;
  int m_wake;
  int m_cool_min;
  bit m_sound;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_snz = 0; m_ringsec = 0; m_wake = 0; m_cool_min = 0; m_sound = 0;
  endtask

  task automatic model_snooze(input int now);
    m_snz++;
    m_wake  = (now + SNOOZE_MINS) % 1440;
    m_mode  = 3;
    m_sound = 0;
  endtask

  task automatic model_cool(input int minute);
    m_cool_min = minute;
    m_wake = 0; m_snz = 0; m_mode = 4; m_sound = 0;
  endtask

  task automatic model_ring();
    m_mode = 2; m_sound = 1; m_ringsec = 0;
  endtask

  task automatic model_update();
    bit timeout;
    if (!alarm_enabled) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: m_mode = 1;
      1: if (cur_t == al_t) begin model_ring(); m_snz = 0; end
      2: begin
        timeout = sec_tick && (m_ringsec + 1 == RING_SECS);
        if (sec_tick) begin m_ringsec++; m_sound = !m_sound; end
        if (btn_dismiss) model_cool(cur_t % 60);
        else if (btn_snooze && m_snz < MAX_SNOOZES) model_snooze(cur_t);
        else if (timeout) begin
          if (m_snz < MAX_SNOOZES) model_snooze(cur_t);
          else model_cool(cur_t % 60);
        end
      end
      3: begin
        if (btn_dismiss) model_cool(cur_t % 60);
        else if (cur_t == m_wake) model_ring();
      end
      4: if ((cur_t % 60) != m_cool_min) m_mode = 1;
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_outputs();
    check_val("alarm_triggered", int'(alarm_triggered), int'(m_mode == 2));
    check_val("sound_en",        int'(sound_en),        int'(m_mode == 2 && m_sound));
    check_val("snoozing",        int'(snoozing),        int'(m_mode == 3));
    check_val("snooze_count",    int'(snooze_count),    m_snz);
    check_val("wake_hours",      int'(wake_hours),      m_wake / 60);
    check_val("wake_mins",       int'(wake_mins),       m_wake % 60);
  endtask

  task automatic apply_times();
    current_hours = 8'(cur_t / 60);
    current_mins  = 8'(cur_t % 60);
    alarm_hours   = 8'(al_t / 60);
    alarm_mins    = 8'(al_t % 60);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit t, input bit s, input bit d);
    sec_tick = t; btn_snooze = s; btn_dismiss = d;
    apply_times();
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    sec_tick = 1'b0; btn_snooze = 1'b0; btn_dismiss = 1'b0;
  endtask

  // From DISARMED/ARMED/COOLDOWN: move the clock on and ring at the next minute.
  task automatic ring_now();
    cur_t = (cur_t + 1) % 1440;
    al_t  = (cur_t + 1) % 1440;
    step(0, 0, 0);
    step(0, 0, 0);
    cur_t = al_t;
    step(0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; alarm_enabled = 1'b0;
    sec_tick = 1'b0; btn_snooze = 1'b0; btn_dismiss = 1'b0;
    cur_t = 7 * 60 + 29; al_t = 7 * 60 + 30;
    apply_times();
    model_reset();
    #12;
    check_val("reset_trig",  int'(alarm_triggered), 0);
    check_val("reset_sound", int'(sound_en),        0);
    check_val("reset_snz",   int'(snoozing),        0);
    check_val("reset_count", int'(snooze_count),    0);
    @(negedge clk);
    reset = 1'b0;

    // Basic ring, beep cadence, dismiss, no re-ring in the next minute.
    alarm_enabled = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    cur_t = 7 * 60 + 30;
    step(0, 0, 0);
    check_val("basic_ring", int'(alarm_triggered), 1);
    check_val("basic_beep0", int'(sound_en), 1);
    step(1, 0, 0);
    check_val("basic_beep1", int'(sound_en), 0);
    step(0, 0, 0);
    step(1, 0, 0);
    check_val("basic_beep2", int'(sound_en), 1);
    step(1, 0, 0);
    step(0, 0, 1);
    check_val("basic_dismiss", int'(alarm_triggered), 0);
    cur_t = 7 * 60 + 31;
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check_val("basic_no_rering", int'(alarm_triggered), 0);

    // Snooze across midnight.
    al_t = 23 * 60 + 55; cur_t = 23 * 60 + 54;
    step(0, 0, 0);
    cur_t = al_t;
    step(0, 0, 0);
    step(0, 1, 0);
    check_val("wrap_snoozing", int'(snoozing), 1);
    check_val("wrap_wake_h", int'(wake_hours), 0);
    check_val("wrap_wake_m", int'(wake_mins), 4);
    check_val("wrap_count", int'(snooze_count), 1);
    for (int i = 0; i < 9; i++) begin
      cur_t = (23 * 60 + 56 + i) % 1440;
      step(0, 0, 0);
    end
    check_val("wrap_rering", int'(alarm_triggered), 1);
    check_val("wrap_rering_count", int'(snooze_count), 1);
    step(0, 0, 1);

    // Snooze limit.
    ring_now();
    for (int k = 0; k < MAX_SNOOZES; k++) begin
      step(0, 1, 0);
      step(0, 0, 0);
      cur_t = m_wake;
      step(0, 0, 0);
    end
    step(0, 1, 0);
    check_val("limit_ignored", int'(alarm_triggered), 1);
    check_val("limit_count", int'(snooze_count), MAX_SNOOZES);
    step(0, 0, 1);
    check_val("limit_dismiss_count", int'(snooze_count), 0);

    // Unattended timeout, first with snoozes left, then at the limit.
    ring_now();
    for (int k = 0; k <= MAX_SNOOZES; k++) begin
      for (int s = 0; s < RING_SECS; s++) step(1, 0, 0);
      if (k < MAX_SNOOZES) begin
        check_val("timeout_snoozing", int'(snoozing), 1);
        check_val("timeout_count", int'(snooze_count), k + 1);
        cur_t = m_wake;
        step(0, 0, 0);
      end
    end
    check_val("timeout_cool_trig", int'(alarm_triggered), 0);
    check_val("timeout_cool_snz", int'(snoozing), 0);
    check_val("timeout_cool_count", int'(snooze_count), 0);

    // Both buttons together, then disable while ringing.
    ring_now();
    step(0, 1, 1);
    check_val("both_cool_snz", int'(snoozing), 0);
    check_val("both_cool_trig", int'(alarm_triggered), 0);
    ring_now();
    step(1, 0, 0);
    alarm_enabled = 1'b0;
    step(0, 0, 0);
    check_val("disable_trig", int'(alarm_triggered), 0);
    check_val("disable_sound", int'(sound_en), 0);
    alarm_enabled = 1'b1;

    // Asynchronous reset while snoozed.
    ring_now();
    step(0, 1, 0);
    check_val("pre_reset_snz", int'(snoozing), 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("areset_snz",   int'(snoozing),     0);
    check_val("areset_count", int'(snooze_count), 0);
    check_val("areset_wake",  int'(wake_mins),    0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    al_t = cur_t;
    step(0, 0, 0);
    check_val("post_reset_armed", int'(alarm_triggered), 0);
    step(0, 0, 0);
    check_val("post_reset_ring", int'(alarm_triggered), 1);

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      if (alarm_enabled && $urandom_range(0, 999) < 2) alarm_enabled = 1'b0;
      else if (!alarm_enabled && $urandom_range(0, 9) == 0) alarm_enabled = 1'b1;
      if ($urandom_range(0, 19) == 0) cur_t = (cur_t + 1) % 1440;
      if ($urandom_range(0, 199) == 0) al_t = (cur_t + $urandom_range(0, 3)) % 1440;
      if (m_mode == 3 && $urandom_range(0, 49) == 0) cur_t = m_wake;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
- Sequences the alarm datapath after the alarm time is set: detects the hours/minutes match, drives the ring enable and beep gating, handles snooze and dismiss, and auto-times-out an unattended ring.
- Sits between the alarm-setting interface (alarm time, enable level) and the sound interface (alarm_triggered, sound_en).
- All time values are binary: hours 0..23, minutes 0..59.

Parameters:
- SNOOZE_MINS, 9: snooze length in minutes; legal range 1..59.
- MAX_SNOOZES, 3: number of snoozes allowed per alarm event; legal range 1..15.
- RING_SECS, 60: seconds of unattended ringing before the timeout action.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sec_tick  input  1  single-cycle pulse, once per second
- current_hours  input  8  time of day, hours
- current_mins  input  8  time of day, minutes
- alarm_hours  input  8  programmed alarm hour
- alarm_mins  input  8  programmed alarm minute
- alarm_enabled  input  1  level; alarm armed when high
- btn_snooze  input  1  single-cycle pulse, debounced upstream
- btn_dismiss  input  1  single-cycle pulse, debounced upstream
- alarm_triggered  output  1  high throughout RINGING
- sound_en  output  1  beep gate to the sound interface
- snoozing  output  1  high throughout SNOOZED
- snooze_count  output  4  snoozes used in the current alarm event
- wake_hours  output  8  pending snooze wake hour
- wake_mins  output  8  pending snooze wake minute

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state DISARMED; every output 0; internal counters 0.
- States: DISARMED, ARMED, RINGING, SNOOZED, COOLDOWN. All transitions are registered, one clk after the qualifying condition.
- Global priority: alarm_enabled=0 in any state -> DISARMED. snooze_count is cleared, all outputs go to 0, and this overrides every other event in the same cycle.
- DISARMED: alarm_enabled=1 -> ARMED.
- ARMED:
  - Compares the live alarm_hours/alarm_mins (not latched) against the current time.
  - Equal -> RINGING; snooze_count is cleared to 0.
- RINGING:
  - alarm_triggered=1.
  - sound_en=1 on entry, then toggles on each sec_tick (1 s on, 1 s off).
  - The ring-seconds counter clears on entry and increments on each sec_tick.
  - btn_dismiss -> COOLDOWN.
  - Else btn_snooze and snooze_count<MAX_SNOOZES -> SNOOZED.
  - Else btn_snooze and snooze_count==MAX_SNOOZES: ignored, stay RINGING.
  - Dismiss wins when both buttons pulse in the same cycle.
  - On the sec_tick that brings the counter to RING_SECS (the timeout tick): auto-snooze if snooze_count<MAX_SNOOZES, otherwise -> COOLDOWN. A button in the same cycle takes precedence over the timeout.
- Entering SNOOZED:
  - snooze_count increments.
  - wake_mins = current_mins+SNOOZE_MINS. If the sum is >=60, subtract 60 and set wake_hours = (current_hours+1) mod 24; otherwise wake_hours = current_hours.
  - Example: 23:55 with SNOOZE_MINS=9 -> wake 00:04.
- SNOOZED:
  - snoozing=1, sound_en=0, alarm_triggered=0.
  - Current time equal to wake_hours:wake_mins -> RINGING. snooze_count is not cleared on this re-entry.
  - btn_dismiss -> COOLDOWN. btn_snooze is ignored.
- COOLDOWN:
  - Latches current_mins on entry.
  - Exits to ARMED when current_mins differs from the latched value. This prevents an immediate re-trigger in the matching minute.
  - wake_hours/wake_mins and snooze_count are cleared on entry.
- Outputs driven 0 outside the listed states: alarm_triggered and sound_en outside RINGING; snoozing outside SNOOZED.
- sec_tick coincident with an entry into RINGING does not toggle sound_en in the entry cycle.
- An alarm time changed while in SNOOZED or COOLDOWN does not affect the pending wake time.

Test Plan:
- Basic ring and dismiss: alarm 07:30, enabled, time steps 07:29 -> 07:30 => alarm_triggered=1 one clk later, sound_en 1/0/1 across 3 sec_ticks. btn_dismiss => COOLDOWN, outputs 0. Time 07:31 => ARMED, no re-ring.
- Snooze with hour/day wrap: alarm 23:55, SNOOZE_MINS=9, btn_snooze at 23:55 => snoozing=1, wake 00:04, snooze_count=1. Time reaches 00:04 => RINGING again.
- Snooze limit: MAX_SNOOZES=3; snooze three times. A fourth btn_snooze is ignored (still ringing, snooze_count=3). btn_dismiss => COOLDOWN, snooze_count=0.
- Timeout: RING_SECS=60, no buttons => after the 60th sec_tick, SNOOZED with snooze_count=1. At the limit (snooze_count=3), timeout => COOLDOWN.
- Simultaneous events and disable: btn_snooze and btn_dismiss pulsed in the same cycle => COOLDOWN. alarm_enabled dropped mid-RINGING => DISARMED next cycle, all outputs 0.
- Asynchronous reset mid-SNOOZED: assert reset between clk edges => all outputs 0 immediately, state DISARMED. Release with alarm_enabled=1 => ARMED after one clk.
